// File: rtl/dca_matrix_row_requester.sv
// Purpose: expand a DCA matrix block descriptor into one LSU row-load request per block row.
// Latency: descriptor accepted in cycle N -> first row request valid in cycle N+1, then one row/cycle.
// Backpressure: requests hold stable while req_ready=0; blk_ready low while a block is in flight
//   (with DCA_ROW_REQUESTER_PREFETCH_EN defined, a one-entry descriptor buffer keeps blk_ready high
//   until it fills, giving back-to-back blocks with no bubble).
// block_info packing, MSB..LSB: {addr, stride_ls3, num_row_m1, num_col_m1, is_signed, is_float, addr_lsa_p3}
module dca_matrix_row_requester #(
  parameter int MAX_NUM_ROW                    = 8,
  parameter int BW_DCA_MATRIX_INFO_ADDR        = 32,
  parameter int BW_DCA_MATRIX_INFO_STRIDE_LS3  = 16,
  parameter int BW_DCA_MATRIX_INFO_NUM_ROW_M1  = 8,
  parameter int BW_DCA_MATRIX_INFO_NUM_COL_M1  = 8,
  parameter int BW_DCA_MATRIX_INFO_IS_SIGNED   = 1,
  parameter int BW_DCA_MATRIX_INFO_IS_FLOAT    = 1,
  parameter int BW_DCA_MATRIX_INFO_ADDR_LSA_P3 = 3,
  localparam int BW_DCA_MATRIX_INFO = BW_DCA_MATRIX_INFO_ADDR + BW_DCA_MATRIX_INFO_STRIDE_LS3 +
                                      BW_DCA_MATRIX_INFO_NUM_ROW_M1 + BW_DCA_MATRIX_INFO_NUM_COL_M1 +
                                      BW_DCA_MATRIX_INFO_IS_SIGNED + BW_DCA_MATRIX_INFO_IS_FLOAT +
                                      BW_DCA_MATRIX_INFO_ADDR_LSA_P3,
  localparam int BW_ROW_IDX = ($clog2(MAX_NUM_ROW) < 1) ? 1 : $clog2(MAX_NUM_ROW),
  localparam int BW_ATTR    = BW_DCA_MATRIX_INFO_IS_SIGNED + BW_DCA_MATRIX_INFO_IS_FLOAT +
                              BW_DCA_MATRIX_INFO_ADDR_LSA_P3
) (
  input  logic                                     clk,
  input  logic                                     rstnn,
  input  logic                                     clear,
  input  logic                                     enable,
  input  logic                                     blk_valid,
  output logic                                     blk_ready,
  input  logic [BW_DCA_MATRIX_INFO-1:0]            block_info,
  input  logic                                     blk_is_last,
  output logic                                     req_valid,
  input  logic                                     req_ready,
  output logic [BW_DCA_MATRIX_INFO_ADDR-1:0]       req_addr,
  output logic [BW_ROW_IDX-1:0]                    req_row_idx,
  output logic [BW_DCA_MATRIX_INFO_NUM_COL_M1-1:0] req_num_col_m1,
  output logic [BW_ATTR-1:0]                       req_attr,
  output logic                                     req_last_row,
  output logic                                     req_last_block,
  output logic                                     done
);

  localparam int BITW     = BW_DCA_MATRIX_INFO_ADDR + 3;
  localparam int OFS_FLT  = BW_DCA_MATRIX_INFO_ADDR_LSA_P3;
  localparam int OFS_SGN  = OFS_FLT + BW_DCA_MATRIX_INFO_IS_FLOAT;
  localparam int OFS_NCOL = OFS_SGN + BW_DCA_MATRIX_INFO_IS_SIGNED;
  localparam int OFS_NROW = OFS_NCOL + BW_DCA_MATRIX_INFO_NUM_COL_M1;
  localparam int OFS_STR  = OFS_NROW + BW_DCA_MATRIX_INFO_NUM_ROW_M1;
  localparam int OFS_ADDR = OFS_STR + BW_DCA_MATRIX_INFO_STRIDE_LS3;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                                   state, state_nxt;
  logic [BITW-1:0]                          bitaddr;
  logic [BW_DCA_MATRIX_INFO_STRIDE_LS3-1:0] stride_q;
  logic [BW_ROW_IDX-1:0]                    nrow_q, row_q, row_inc;
  logic [BW_DCA_MATRIX_INFO_NUM_COL_M1-1:0] col_q;
  logic [BW_ATTR-1:0]                       attr_q;
  logic                                     last_row_q, last_blk_q, done_q;

  logic                                     blk_hs, req_hs, last_hs, load;
  logic [BW_DCA_MATRIX_INFO-1:0]            src_info;
  logic                                     src_last;
  logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] src_nrow_full;
  logic [BW_ROW_IDX-1:0]                    src_nrow;
  logic                                     unused_nrow_bits;

  assign blk_hs  = blk_valid & blk_ready & enable;
  assign req_hs  = req_valid & req_ready & enable;
  assign last_hs = req_hs & last_row_q;
  assign row_inc = row_q + BW_ROW_IDX'(1);

`ifdef DCA_ROW_REQUESTER_PREFETCH_EN
  logic                          buf_full, buf_last, buf_push, load_from_buf;
  logic [BW_DCA_MATRIX_INFO-1:0] buf_info;

  // A buffered descriptor takes over on the last-row handshake; a fresh one goes straight
  // to the active registers when nothing is buffered and the block is ending (or idle).
  assign load_from_buf = last_hs & buf_full;
  assign load          = load_from_buf | (blk_hs & ((state == S_IDLE) | last_hs));
  assign buf_push      = blk_hs & (state == S_ISSUE) & ~last_hs;
  assign src_info      = load_from_buf ? buf_info : block_info;
  assign src_last      = load_from_buf ? buf_last : blk_is_last;

  // One-entry descriptor buffer; blk_ready is low while it holds a descriptor
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      buf_full <= 1'b0;
      buf_info <= '0;
      buf_last <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        buf_full <= 1'b0;
      end else if (buf_push) begin
        buf_full <= 1'b1;
        buf_info <= block_info;
        buf_last <= blk_is_last;
      end else if (load_from_buf) begin
        buf_full <= 1'b0;
      end
    end
  end
`else
  assign load     = blk_hs;
  assign src_info = block_info;
  assign src_last = blk_is_last;
`endif

  // num_row_m1 is truncated to the row-index width; upper bits are intentionally ignored
  assign src_nrow_full    = src_info[OFS_NROW +: BW_DCA_MATRIX_INFO_NUM_ROW_M1];
  assign src_nrow         = src_nrow_full[BW_ROW_IDX-1:0];
  assign unused_nrow_bits = ^src_nrow_full;

  // FSM state register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: clear wins, a new block (re)enters ISSUE, the last row returns to IDLE
  always_comb begin
    state_nxt = state;
    if (enable) begin
      if (clear)        state_nxt = S_IDLE;
      else if (load)    state_nxt = S_ISSUE;
      else if (last_hs) state_nxt = S_IDLE;
    end
  end

  // FSM outputs; both are functions of registers only
  always_comb begin
    req_valid = (state == S_ISSUE);
`ifdef DCA_ROW_REQUESTER_PREFETCH_EN
    blk_ready = ~buf_full;
`else
    blk_ready = (state == S_IDLE);
`endif
  end

  // Active block registers: load on a new block, step address/row on each non-final row handshake
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      bitaddr    <= '0;
      stride_q   <= '0;
      nrow_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      attr_q     <= '0;
      last_row_q <= 1'b0;
      last_blk_q <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        row_q      <= '0;
        last_row_q <= (nrow_q == '0);
      end else if (load) begin
        bitaddr    <= {src_info[OFS_ADDR +: BW_DCA_MATRIX_INFO_ADDR], 3'b000};
        stride_q   <= src_info[OFS_STR +: BW_DCA_MATRIX_INFO_STRIDE_LS3];
        nrow_q     <= src_nrow;
        row_q      <= '0;
        last_row_q <= (src_nrow == '0);
        col_q      <= src_info[OFS_NCOL +: BW_DCA_MATRIX_INFO_NUM_COL_M1];
        attr_q     <= {src_info[0 +: BW_DCA_MATRIX_INFO_ADDR_LSA_P3],
                       src_info[OFS_FLT +: BW_DCA_MATRIX_INFO_IS_FLOAT],
                       src_info[OFS_SGN +: BW_DCA_MATRIX_INFO_IS_SIGNED]};
        last_blk_q <= src_last;
      end else if (req_hs && !last_row_q) begin
        row_q      <= row_inc;
        bitaddr    <= bitaddr + BITW'(stride_q);
        last_row_q <= (row_inc == nrow_q);
      end
    end
  end

  // done pulses the cycle after the final row of the final block is taken
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)      done_q <= 1'b0;
    else if (enable) done_q <= ~clear & last_hs & last_blk_q;
  end

  assign req_addr       = bitaddr[BITW-1:3];
  assign req_row_idx    = row_q;
  assign req_num_col_m1 = col_q;
  assign req_attr       = attr_q;
  assign req_last_row   = last_row_q;
  assign req_last_block = last_blk_q;
  assign done           = done_q;

endmodule

// File: tb/tb_dca_matrix_row_requester.sv
// Directed bench for dca_matrix_row_requester: reset, row expansion, backpressure, single row,
// wrap, clear, enable stall, async reset and back-to-back blocks (gap depends on prefetch macro).
module tb_dca_matrix_row_requester;

`ifdef DCA_ROW_REQUESTER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstnn, clear, enable, blk_valid, blk_is_last, req_ready;
  logic [68:0] block_info;
  logic        blk_ready, req_valid, req_last_row, req_last_block, done;
  logic [31:0] req_addr;
  logic [2:0]  req_row_idx;
  logic [7:0]  req_num_col_m1;
  logic [4:0]  req_attr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dca_matrix_row_requester dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .block_info(block_info), .blk_is_last(blk_is_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_row_idx(req_row_idx),
    .req_num_col_m1(req_num_col_m1), .req_attr(req_attr), .req_last_row(req_last_row),
    .req_last_block(req_last_block), .done(done)
  );

  function automatic logic [68:0] mk(input logic [31:0] a, input logic [15:0] s, input logic [7:0] nr,
                                     input logic [7:0] nc, input logic sg, input logic fl,
                                     input logic [2:0] lsa);
    return {a, s, nr, nc, sg, fl, lsa};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a descriptor until it is accepted (bounded), then drop blk_valid
  task automatic load_block(input logic [68:0] info, input logic last);
    blk_valid   = 1'b1;
    block_info  = info;
    blk_is_last = last;
    for (int i = 0; i < 10 && !blk_ready; i++) step();
    chk("load_rdy", blk_ready, 1);
    step();
    blk_valid = 1'b0;
  endtask

  logic [68:0] blks [2];
  int          cyc_log [4];
  logic [31:0] addr_log [4];
  int          k, idx, nreq;
  logic        acc;

  initial begin
    rstnn = 1'b0; clear = 1'b0; enable = 1'b1; blk_valid = 1'b0;
    blk_is_last = 1'b0; req_ready = 1'b1; block_info = '0;
    #2;
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_row", req_row_idx, 0);
    chk("rst_col", req_num_col_m1, 0);
    chk("rst_attr", req_attr, 0);
    chk("rst_last_row", req_last_row, 0);
    chk("rst_last_block", req_last_block, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rstnn = 1'b1;
    step();

    // Basic 4-row block, stride 32 B
    load_block(mk(32'h1000, 16'h100, 8'd3, 8'd5, 1'b1, 1'b0, 3'b101), 1'b0);
    chk("basic_col", req_num_col_m1, 5);
    chk("basic_attr", req_attr, 5'b10101);
    chk("basic_last_block", req_last_block, 0);
    chk("basic_blk_ready_busy", blk_ready, PF);
    for (int i = 0; i < 4; i++) begin
      chk("basic_vld", req_valid, 1);
      chk("basic_addr", req_addr, 32'h1000 + 32 * i);
      chk("basic_row", req_row_idx, i);
      chk("basic_last_row", req_last_row, (i == 3));
      step();
    end
    chk("basic_idle_vld", req_valid, 0);
    chk("basic_idle_rdy", blk_ready, 1);
    chk("basic_done", done, 0);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    load_block(mk(32'h1000, 16'h100, 8'd3, 8'd5, 1'b1, 1'b0, 3'b101), 1'b0);
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      req_ready = (c % 3 == 0);
      chk("bp_vld", req_valid, 1);
      chk("bp_addr", req_addr, 32'h1000 + 32 * k);
      chk("bp_row", req_row_idx, k);
      if (req_ready) k++;
      step();
    end
    req_ready = 1'b1;
    chk("bp_count", k, 4);
    chk("bp_idle", req_valid, 0);

    // Single row, last block
    load_block(mk(32'h2000, 16'h100, 8'd0, 8'd1, 1'b0, 1'b1, 3'b000), 1'b1);
    chk("single_vld", req_valid, 1);
    chk("single_last_row", req_last_row, 1);
    chk("single_last_block", req_last_block, 1);
    chk("single_done_early", done, 0);
    step();
    chk("single_idle", req_valid, 0);
    chk("single_done", done, 1);
    step();
    chk("single_done_off", done, 0);

    // Address wrap
    load_block(mk(32'hFFFF_FFE0, 16'h100, 8'd1, 8'd0, 1'b0, 1'b0, 3'b000), 1'b0);
    chk("wrap_addr0", req_addr, 32'hFFFF_FFE0);
    step();
    chk("wrap_addr1", req_addr, 32'h0);
    chk("wrap_last_row", req_last_row, 1);
    step();
    chk("wrap_idle", req_valid, 0);

    // Clear after second handshake of a last block
    load_block(mk(32'h1000, 16'h100, 8'd3, 8'd0, 1'b0, 1'b0, 3'b000), 1'b1);
    step();
    step();
    chk("clr_row_pre", req_row_idx, 2);
    chk("clr_addr_pre", req_addr, 32'h1040);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_rdy", blk_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("clr_no_req", req_valid, 0);
      chk("clr_no_done", done, 0);
      step();
    end

    // enable=0 for 5 cycles mid-block, with a descriptor offered meanwhile
    load_block(mk(32'h1000, 16'h100, 8'd3, 8'd0, 1'b0, 1'b0, 3'b000), 1'b1);
    step();
    enable = 1'b0;
    blk_valid = 1'b1;
    block_info = mk(32'h5000, 16'h100, 8'd0, 8'd0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_vld", req_valid, 1);
      chk("en_addr", req_addr, 32'h1020);
      chk("en_row", req_row_idx, 1);
      chk("en_last_row", req_last_row, 0);
      chk("en_rdy", blk_ready, PF);
    end
    blk_valid = 1'b0;
    enable = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("en_resume_row", req_row_idx, i);
      chk("en_resume_addr", req_addr, 32'h1000 + 32 * i);
      step();
    end
    chk("en_idle", req_valid, 0);
    chk("en_done", done, 1);
    step();

    // Asynchronous reset mid-block
    load_block(mk(32'h7000, 16'h100, 8'd3, 8'd2, 1'b1, 1'b1, 3'b111), 1'b1);
    step();
    #2 rstnn = 1'b0;
    #1;
    chk("arst_vld", req_valid, 0);
    chk("arst_addr", req_addr, 0);
    chk("arst_row", req_row_idx, 0);
    chk("arst_attr", req_attr, 0);
    chk("arst_rdy", blk_ready, 1);
    @(negedge clk);
    rstnn = 1'b1;
    step();

    // Back-to-back 2-row blocks
    blks[0] = mk(32'h3000, 16'h100, 8'd1, 8'd0, 1'b0, 1'b0, 3'b000);
    blks[1] = mk(32'h4000, 16'h100, 8'd1, 8'd0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++) begin cyc_log[i] = 0; addr_log[i] = '0; end
    idx = 0; nreq = 0;
    blk_valid = 1'b1; block_info = blks[0]; blk_is_last = 1'b0; req_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = blk_valid & blk_ready;
      if (req_valid && nreq < 4) begin
        cyc_log[nreq] = c;
        addr_log[nreq] = req_addr;
        nreq++;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 2) block_info = blks[idx];
        else         blk_valid = 1'b0;
      end
    end
    chk("b2b_count", nreq, 4);
    chk("b2b_addr0", addr_log[0], 32'h3000);
    chk("b2b_addr1", addr_log[1], 32'h3020);
    chk("b2b_addr2", addr_log[2], 32'h4000);
    chk("b2b_addr3", addr_log[3], 32'h4020);
    chk("b2b_gap01", cyc_log[1] - cyc_log[0], 1);
    chk("b2b_gap12", cyc_log[2] - cyc_log[1], PF ? 1 : 2);
    chk("b2b_gap23", cyc_log[3] - cyc_log[2], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
